// File: rtl/alu_pkg.sv
// Purpose : shared operation encodings and types for the 8-bit ALU.
// Latency : n/a (declarations only).
// Backpressure: n/a (declarations only).
package alu_pkg;

  typedef logic [3:0] alu_op_t;

  localparam int ALU_WIDTH = 8;

  localparam alu_op_t ALU_PASS_A = 4'b0000;  // a
  localparam alu_op_t ALU_INC    = 4'b0001;  // a + 1
  localparam alu_op_t ALU_ADD    = 4'b0010;  // a + b
  localparam alu_op_t ALU_ADC    = 4'b0011;  // a + b + cin
  localparam alu_op_t ALU_SUB    = 4'b0100;  // a + ~b + 1
  localparam alu_op_t ALU_SBC    = 4'b0101;  // a + ~b + cin
  localparam alu_op_t ALU_DEC    = 4'b0110;  // a - 1
  localparam alu_op_t ALU_PASS_B = 4'b0111;  // b
  localparam alu_op_t ALU_AND    = 4'b1000;  // a & b
  localparam alu_op_t ALU_OR     = 4'b1001;  // a | b
  localparam alu_op_t ALU_XOR    = 4'b1010;  // a ^ b
  localparam alu_op_t ALU_NOT_A  = 4'b1011;  // ~a
  localparam alu_op_t ALU_NOT_B  = 4'b1100;  // ~b
  localparam alu_op_t ALU_SHL    = 4'b1101;  // a << 1, zero fill
  localparam alu_op_t ALU_SHR    = 4'b1110;  // a >> 1, logical
  localparam alu_op_t ALU_ZERO   = 4'b1111;  // 0

endpackage : alu_pkg

// File: rtl/alu_comb.sv
// Purpose : purely combinational ALU function f(a, b, cin, sel).
// Latency : 0 cycles (combinational).
// Backpressure: none; output follows inputs continuously.
//
// Ports:
//   i_a, i_b  operands (WIDTH)
//   i_cin     carry/borrow control, used by ADC and SBC only
//   i_sel     operation code (alu_op_t)
//   o_f       result (WIDTH), carry-out discarded
module alu_comb
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_cin,
  input  alu_op_t          i_sel,
  output logic [WIDTH-1:0] o_f
);

  // Adder is one bit wider than the operands; the top bit is the carry-out,
  // which has no consumer and is dropped on truncation.
  logic [WIDTH:0] w_sum;
  logic           w_unused_carry;

  logic [WIDTH:0] w_a_ext;
  logic [WIDTH:0] w_b_ext;
  logic [WIDTH:0] w_nb_ext;
  logic [WIDTH:0] w_cin_ext;
  logic [WIDTH:0] w_one_ext;
  logic [WIDTH:0] w_ones_ext;

  assign w_a_ext    = {1'b0, i_a};
  assign w_b_ext    = {1'b0, i_b};
  assign w_nb_ext   = {1'b0, ~i_b};
  assign w_cin_ext  = {{WIDTH{1'b0}}, i_cin};
  assign w_one_ext  = {{WIDTH{1'b0}}, 1'b1};
  // Adding all-ones modulo 2^WIDTH is the decrement.
  assign w_ones_ext = {1'b0, {WIDTH{1'b1}}};

  always_comb begin
    w_sum = '0;
    o_f   = '0;
    case (i_sel)
      ALU_PASS_A: o_f = i_a;
      ALU_INC: begin
        w_sum = w_a_ext + w_one_ext;
        o_f   = w_sum[WIDTH-1:0];
      end
      ALU_ADD: begin
        w_sum = w_a_ext + w_b_ext;
        o_f   = w_sum[WIDTH-1:0];
      end
      ALU_ADC: begin
        w_sum = w_a_ext + w_b_ext + w_cin_ext;
        o_f   = w_sum[WIDTH-1:0];
      end
      ALU_SUB: begin
        w_sum = w_a_ext + w_nb_ext + w_one_ext;
        o_f   = w_sum[WIDTH-1:0];
      end
      ALU_SBC: begin
        // cin=1 is a plain subtract, cin=0 additionally borrows one.
        w_sum = w_a_ext + w_nb_ext + w_cin_ext;
        o_f   = w_sum[WIDTH-1:0];
      end
      ALU_DEC: begin
        w_sum = w_a_ext + w_ones_ext;
        o_f   = w_sum[WIDTH-1:0];
      end
      ALU_PASS_B: o_f = i_b;
      ALU_AND:    o_f = i_a & i_b;
      ALU_OR:     o_f = i_a | i_b;
      ALU_XOR:    o_f = i_a ^ i_b;
      ALU_NOT_A:  o_f = ~i_a;
      ALU_NOT_B:  o_f = ~i_b;
      ALU_SHL:    o_f = {i_a[WIDTH-2:0], 1'b0};
      ALU_SHR:    o_f = {1'b0, i_a[WIDTH-1:1]};
      ALU_ZERO:   o_f = '0;
      // Unknown select resolves to zero rather than holding a prior value.
      default:    o_f = '0;
    endcase
  end

  assign w_unused_carry = w_sum[WIDTH];

endmodule : alu_comb

// File: rtl/alu.sv
// Purpose : 16-function ALU with a single registered result.
// Latency : 1 cycle; y reflects inputs sampled at the previous rising edge.
// Backpressure: none; no enable or handshake, y updates every cycle.
//
// Ports:
//   clk    clock, rising edge
//   rst_n  asynchronous active-low reset, clears y immediately
//   a, b   operands (WIDTH)
//   cin    carry/borrow control for ADC and SBC
//   sel    operation code (alu_pkg encodings)
//   y      registered result (WIDTH)
module alu
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic [3:0]       sel,
  output logic [WIDTH-1:0] y
);

  logic [WIDTH-1:0] w_f;
  logic [WIDTH-1:0] r_y;

  alu_comb #(
    .WIDTH (WIDTH)
  ) u_alu_comb (
    .i_a   (a),
    .i_b   (b),
    .i_cin (cin),
    .i_sel (sel),
    .o_f   (w_f)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_y <= '0;
    end else begin
      r_y <= w_f;
    end
  end

  assign y = r_y;

endmodule : alu

// File: tb/tb_alu.sv
// Purpose : scoreboard bench for alu; directed table vectors plus random ops.
// Latency : expects y one rising edge after inputs are driven.
// Backpressure: none; one expected result is queued per driven cycle.
module tb_alu;

  logic       clk;
  logic       rst_n;
  logic [7:0] a;
  logic [7:0] b;
  logic       cin;
  logic [3:0] sel;
  logic [7:0] y;

  typedef struct {
    logic [7:0] exp;
    string      name;
  } sb_item_t;

  sb_item_t sb_q[$];
  int       n_checks;
  int       n_errors;

  alu #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .sel   (sel),
    .y     (y)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: y=%h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model in plain integer arithmetic, reduced modulo 256.
  function automatic logic [7:0] ref_model(input int av, input int bv, input int cv, input int sv);
    int r;
    case (sv)
      0:  r = av;
      1:  r = (av + 1) % 256;
      2:  r = (av + bv) % 256;
      3:  r = (av + bv + cv) % 256;
      4:  r = (av - bv + 256) % 256;
      5:  r = (av - bv - 1 + cv + 512) % 256;
      6:  r = (av - 1 + 256) % 256;
      7:  r = bv;
      8:  r = av & bv;
      9:  r = av | bv;
      10: r = av ^ bv;
      11: r = 255 - av;
      12: r = 255 - bv;
      13: r = (av * 2) % 256;
      14: r = av / 2;
      default: r = 0;
    endcase
    return r[7:0];
  endfunction

  // Drive inputs just after a falling edge without queuing an expectation.
  task automatic set_inputs(input logic [7:0] av, input logic [7:0] bv,
                            input logic cv, input logic [3:0] sv);
    @(negedge clk);
    a   = av;
    b   = bv;
    cin = cv;
    sel = sv;
  endtask

  // Drive inputs and queue the result expected at the next rising edge.
  task automatic drive_exp(input logic [7:0] av, input logic [7:0] bv, input logic cv,
                           input logic [3:0] sv, input logic [7:0] exp, input string nm);
    sb_item_t it;
    set_inputs(av, bv, cv, sv);
    it.exp  = exp;
    it.name = nm;
    sb_q.push_back(it);
  endtask

  task automatic drive_rand(input string nm);
    logic [7:0] av;
    logic [7:0] bv;
    logic       cv;
    logic [3:0] sv;
    av = 8'($urandom_range(0, 255));
    bv = 8'($urandom_range(0, 255));
    cv = 1'($urandom_range(0, 1));
    sv = 4'($urandom_range(0, 15));
    drive_exp(av, bv, cv, sv, ref_model(int'(av), int'(bv), int'(cv), int'(sv)), nm);
  endtask

  // Monitor: one result per rising edge, sampled 1 time unit after the edge.
  always @(posedge clk) begin
    sb_item_t it;
    #1;
    if (sb_q.size() != 0) begin
      it = sb_q.pop_front();
      check(it.name, y, it.exp);
    end
  end

  // Watchdog so the run always terminates.
  initial begin
    #2000000;
    $display("FAIL watchdog: y=%h expected simulation end", y);
    $fatal(1, "watchdog expired");
  end

  logic [7:0] arith_exp [8];
  logic [7:0] logic_exp [8];

  initial begin
    n_checks = 0;
    n_errors = 0;
    arith_exp = '{8'h93, 8'h94, 8'h3A, 8'h3A, 8'hEC, 8'hEC, 8'h92, 8'hA7};
    logic_exp = '{8'h83, 8'hB7, 8'h34, 8'h6C, 8'h58, 8'h26, 8'h49, 8'h00};

    // Reset with arbitrary inputs.
    rst_n = 1'b0;
    a     = 8'h5A;
    b     = 8'hC3;
    cin   = 1'b1;
    sel   = 4'h2;
    #1;
    check("reset_immediate", y, 8'h00);
    repeat (3) @(posedge clk);
    #1;
    check("reset_hold", y, 8'h00);

    // Release between edges; y must stay 0 until the next rising edge.
    drive_exp(8'h11, 8'hA5, 1'b0, 4'h7, 8'hA5, "release_first");
    #2;
    rst_n = 1'b1;
    #1;
    check("release_hold", y, 8'h00);

    // Arithmetic and logic sweeps.
    for (int i = 0; i < 8; i++)
      drive_exp(8'h93, 8'hA7, (i == 5), 4'(i), arith_exp[i], $sformatf("arith_sel%0d", i));
    for (int i = 0; i < 8; i++)
      drive_exp(8'h93, 8'hA7, 1'b0, 4'(i + 8), logic_exp[i], $sformatf("logic_sel%0d", i + 8));

    // Carry/borrow control.
    drive_exp(8'h10, 8'h01, 1'b0, 4'h3, 8'h11, "adc_cin0");
    drive_exp(8'h10, 8'h01, 1'b1, 4'h3, 8'h12, "adc_cin1");
    drive_exp(8'h10, 8'h01, 1'b0, 4'h5, 8'h0E, "sbc_cin0");
    drive_exp(8'h10, 8'h01, 1'b1, 4'h5, 8'h0F, "sbc_cin1");
    // cin must be ignored outside ADC/SBC.
    drive_exp(8'h10, 8'h01, 1'b1, 4'h2, 8'h11, "add_ignores_cin");
    drive_exp(8'h10, 8'h01, 1'b0, 4'h4, 8'h0F, "sub_ignores_cin");

    // Wrap-around.
    drive_exp(8'hFF, 8'h00, 1'b0, 4'h1, 8'h00, "wrap_inc");
    drive_exp(8'h00, 8'h00, 1'b0, 4'h6, 8'hFF, "wrap_dec");
    drive_exp(8'h80, 8'h00, 1'b0, 4'hD, 8'h00, "wrap_shl");
    drive_exp(8'h01, 8'h00, 1'b0, 4'hE, 8'h00, "shr_lsb_out");

    // Random ops, select changing every cycle: checks the one-edge lag.
    for (int i = 0; i < 200; i++) drive_rand("rand_a");

    // Async reset between edges with a result in flight.
    drive_exp(8'h93, 8'hA7, 1'b0, 4'h7, 8'hA7, "pre_reset");
    set_inputs(8'h93, 8'hA7, 1'b0, 4'h9);
    @(posedge clk);
    #3;
    check("pre_reset_b7", y, 8'hB7);
    #1;
    rst_n = 1'b0;
    #1;
    check("async_clear", y, 8'h00);
    set_inputs(8'hFF, 8'h01, 1'b1, 4'h2);
    @(posedge clk);
    #1;
    check("reset_mid_hold", y, 8'h00);
    drive_exp(8'h93, 8'hA7, 1'b0, 4'hA, 8'h34, "post_reset_first");
    #2;
    rst_n = 1'b1;
    #1;
    check("post_release_hold", y, 8'h00);

    for (int i = 0; i < 100; i++) drive_rand("rand_b");

    // Drain the scoreboard within a bounded number of edges.
    for (int i = 0; i < 10 && sb_q.size() != 0; i++) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (sb_q.size() != 0) begin
      n_errors++;
      $display("FAIL drain: pending=%0d expected 0", sb_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule : tb_alu
